// File: rtl/addsub_serial_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the serial add/subtract sequencer:
//   - addsub_state_t : controller state encoding (IDLE, RUN, DONE)
//   - NIBBLE_W       : width of the shared adder slice
//   - OP_ADD/OP_SUB  : operation encodings carried on 'op'
//   - signed_ovf     : two's-complement overflow from the MSB column
// -----------------------------------------------------------------------------
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  localparam int NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Overflow occurs when both addends share a sign and the sum's sign differs.
  // b_msb must already be the effective (possibly inverted) operand bit.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub_serial_ctrl_if.sv
// -----------------------------------------------------------------------------
// addsub_serial_ctrl_if
// Request/response bundle between a requester and the serial add/sub
// sequencer. Operand width is 4*WORDS.
//   start, op, a, b                         : request (requester -> sequencer)
//   busy, done, result, cout, overflow      : status/response (sequencer -> requester)
// Modports: master = requester side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface addsub_serial_ctrl_if #(
  parameter int WORDS = 4
);
  logic                   start;
  logic                   op;
  logic [4*WORDS-1:0]     a;
  logic [4*WORDS-1:0]     b;
  logic                   busy;
  logic                   done;
  logic [4*WORDS-1:0]     result;
  logic                   cout;
  logic                   overflow;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/addsub_serial_ctrl_slice.sv
// -----------------------------------------------------------------------------
// addsub4_slice
// Combinational 4-bit adder/subtractor column.
//   a, b : nibble operands
//   m    : 1 = subtract (b is inverted internally; caller supplies cin=1
//          on the first nibble to complete the two's complement)
//   cin  : carry in
//   s    : 4-bit sum
//   cout : carry out of the nibble
// -----------------------------------------------------------------------------
module addsub4_slice
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                m,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic [NIBBLE_W-1:0] b_eff_s;
  logic [NIBBLE_W:0]   sum_s;

  // Conditional inversion of b followed by a widened add to expose the carry.
  always_comb begin
    b_eff_s = b ^ {NIBBLE_W{m}};
    sum_s   = {1'b0, a} + {1'b0, b_eff_s} + {{NIBBLE_W{1'b0}}, cin};
  end

  assign s    = sum_s[NIBBLE_W-1:0];
  assign cout = sum_s[NIBBLE_W];

endmodule

// File: rtl/addsub_serial_ctrl.sv
// -----------------------------------------------------------------------------
// addsub_serial_ctrl
// Computes a 4*WORDS-bit add or subtract by running one 4-bit slice over
// WORDS consecutive cycles, least significant nibble first, with the carry
// held in a register between nibbles.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (aborts any operation in flight)
//   bus  : slave side of addsub_serial_ctrl_if
//          start/op/a/b sampled only in IDLE; busy high in RUN and DONE;
//          done pulses one cycle with result/cout/overflow valid and held
//          until the next completion. All outputs are registered.
// -----------------------------------------------------------------------------
module addsub_serial_ctrl
  import addsub_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  addsub_serial_ctrl_if.slave  bus
);

  localparam int W     = NIBBLE_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  addsub_state_t      state_r;
  addsub_state_t      state_s;

  logic [IDX_W-1:0]   idx_r;
  logic               c_r;
  logic               op_r;
  logic [W-1:0]       sa_r;
  logic [W-1:0]       sb_r;
  logic [W-1:0]       acc_r;

  logic [W-1:0]       result_r;
  logic               cout_r;
  logic               ovf_r;
  logic               busy_r;
  logic               done_r;

  logic [NIBBLE_W-1:0] sum_s;
  logic                carry_s;
  logic                last_s;
  logic [W-1:0]        acc_next_s;

  addsub4_slice u_slice (
    .a    (sa_r[NIBBLE_W-1:0]),
    .b    (sb_r[NIBBLE_W-1:0]),
    .m    (op_r),
    .cin  (c_r),
    .s    (sum_s),
    .cout (carry_s)
  );

  // Datapath helpers: last-nibble flag and acc with the new nibble shifted in at the top.
  always_comb begin
    last_s     = (idx_r == LAST_IDX);
    acc_next_s = {sum_s, acc_r[W-1:NIBBLE_W]};
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand shifters, carry chain, nibble index and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r    <= '0;
      c_r      <= 1'b0;
      op_r     <= OP_ADD;
      sa_r     <= '0;
      sb_r     <= '0;
      acc_r    <= '0;
      result_r <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            sa_r  <= bus.a;
            sb_r  <= bus.b;
            op_r  <= bus.op;
            // Subtract = a + ~b + 1; the +1 enters as the first carry-in.
            c_r   <= bus.op;
            idx_r <= '0;
          end
        end
        RUN: begin
          acc_r <= acc_next_s;
          sa_r  <= {{NIBBLE_W{1'b0}}, sa_r[W-1:NIBBLE_W]};
          sb_r  <= {{NIBBLE_W{1'b0}}, sb_r[W-1:NIBBLE_W]};
          c_r   <= carry_s;
          if (last_s) begin
            result_r <= acc_next_s;
            cout_r   <= carry_s;
            ovf_r    <= signed_ovf(sa_r[NIBBLE_W-1],
                                   sb_r[NIBBLE_W-1] ^ op_r,
                                   sum_s[NIBBLE_W-1]);
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          idx_r <= idx_r;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

  // Status flags registered from the next state so they align with state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == DONE);
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.result   = result_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// -----------------------------------------------------------------------------
// tb_addsub_serial_ctrl
// Scoreboard bench: stimulus pushes hand-computed expectations; per-DUT
// monitors pop and compare whenever done is seen. One 16-bit and one 8-bit
// instance share clk and rst.
// -----------------------------------------------------------------------------
module tb_addsub_serial_ctrl;

  typedef struct {
    logic [15:0] res;
    logic        co;
    logic        ov;
    int          k;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;

  exp_t q4[$];
  exp_t q2[$];

  addsub_serial_ctrl_if #(.WORDS(4)) bus4 ();
  addsub_serial_ctrl_if #(.WORDS(2)) bus2 ();

  addsub_serial_ctrl #(.WORDS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  addsub_serial_ctrl #(.WORDS(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 16-bit monitor
  always @(negedge clk) begin
    if (bus4.done === 1'b1) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w4_unexpected_done: done=1 with no operation outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("w4_result_cout_ovf", {15'd0, bus4.result, bus4.cout, bus4.overflow},
            {15'd0, e.res, e.co, e.ov});
        chk("w4_latency", 32'(cyc - e.k), 32'd4);
      end
    end
  end

  // 8-bit monitor
  always @(negedge clk) begin
    if (bus2.done === 1'b1) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w2_unexpected_done: done=1 with no operation outstanding (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("w2_result_cout_ovf", {22'd0, bus2.result, bus2.cout, bus2.overflow},
            {22'd0, e.res[7:0], e.co, e.ov});
        chk("w2_latency", 32'(cyc - e.k), 32'd2);
      end
    end
  end

  // Called at a negedge; start is sampled at the next posedge, then operands are scrambled.
  task automatic issue4(input logic opv, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] er, input logic eco, input logic eov,
                        input bit expect_done);
    exp_t e;
    bus4.start = 1'b1;
    bus4.op    = opv;
    bus4.a     = av;
    bus4.b     = bv;
    if (expect_done) begin
      e.res = er; e.co = eco; e.ov = eov; e.k = cyc + 1;
      q4.push_back(e);
    end
    @(negedge clk);
    bus4.start = 1'b0;
    bus4.op    = ~opv;
    bus4.a     = ~av;
    bus4.b     = 16'hA5A5;
  endtask

  task automatic issue2(input logic opv, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] er, input logic eco, input logic eov);
    exp_t e;
    bus2.start = 1'b1;
    bus2.op    = opv;
    bus2.a     = av;
    bus2.b     = bv;
    e.res = {8'd0, er}; e.co = eco; e.ov = eov; e.k = cyc + 1;
    q2.push_back(e);
    @(negedge clk);
    bus2.start = 1'b0;
    bus2.op    = ~opv;
    bus2.a     = ~av;
    bus2.b     = 8'h5A;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus4.start = 1'b0; bus4.op = 1'b0; bus4.a = 16'd0; bus4.b = 16'd0;
    bus2.start = 1'b0; bus2.op = 1'b0; bus2.a = 8'd0;  bus2.b = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy4",   {31'd0, bus4.busy}, 32'd0);
    chk("reset_done4",   {31'd0, bus4.done}, 32'd0);
    chk("reset_result4", {16'd0, bus4.result}, 32'd0);
    chk("reset_busy2",   {31'd0, bus2.busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors
    issue4(1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b1); repeat (6) @(negedge clk);
    issue4(1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b1); repeat (6) @(negedge clk);
    issue4(1'b1, 16'hABCD, 16'hABCD, 16'h0000, 1'b1, 1'b0, 1'b1); repeat (6) @(negedge clk);
    issue4(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1); repeat (6) @(negedge clk);
    issue4(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b1); repeat (6) @(negedge clk);

    // Start pulses in RUN (j=1) and DONE (j=4) must be ignored; busy over RUN+DONE only.
    issue4(1'b0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j <= 5; j++) begin
      chk($sformatf("busy_window_%0d", j), {31'd0, bus4.busy}, {31'd0, (j <= 4)});
      if (j == 1 || j == 4) begin
        bus4.start = 1'b1; bus4.op = 1'b1; bus4.a = 16'hFFFF; bus4.b = 16'h1111;
      end else begin
        bus4.start = 1'b0;
      end
      @(negedge clk);
    end
    bus4.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("ignored_start_result", {16'd0, bus4.result}, 32'h0003);

    // Reset two cycles into RUN: aborted op must not complete.
    issue4(1'b0, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy",   {31'd0, bus4.busy}, 32'd0);
    chk("abort_done",   {31'd0, bus4.done}, 32'd0);
    chk("abort_result", {16'd0, bus4.result}, 32'd0);
    chk("abort_cout_ovf", {30'd0, bus4.cout, bus4.overflow}, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue4(1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b1); repeat (6) @(negedge clk);

    // 8-bit instance
    issue2(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0); repeat (4) @(negedge clk);
    issue2(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1); repeat (4) @(negedge clk);

    repeat (4) @(negedge clk);
    chk("w4_pending", 32'(q4.size()), 32'd0);
    chk("w2_pending", 32'(q2.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_serial_ctrl.md
# addsub_serial_ctrl

Sequencer that computes a multi-nibble add or subtract by time-sharing a single 4-bit adder/subtractor slice across WORDS cycles, rippling the carry through a register between nibbles. It sits between a requester issuing full-width operations and the 4-bit slice. It trades latency for area: one slice serves any operand width that is a multiple of 4.

## Interface

- WORDS, default 4: nibbles per operand. Operand width W = 4*WORDS. Legal range is 2..16.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  operation request; sampled only in IDLE.
- op  input  1  0 = add (a+b), 1 = subtract (a−b); sampled with start.
- a  input  W  operand A; sampled with start.
- b  input  W  operand B; sampled with start.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle pulse; result, cout and overflow are valid while it is high.
- result  output  W  sum or difference; held until the next completion.
- cout  output  1  final carry out. For subtract, 1 means no borrow (a ≥ b unsigned).
- overflow  output  1  two's-complement signed overflow of the full-width operation.

## Operation

- States are IDLE, RUN and DONE, with a nibble index idx of width clog2(WORDS).
- **IDLE**
  - With start=1: latch a into shift register sa, b into sb and op into op_r.
  - Set carry register c to op (the subtract injects +1). Set idx to 0. Go to RUN.
  - With start=0: stay in IDLE.
- **RUN**, each cycle:
  - The slice computes sa[3:0] + (sb[3:0] XOR {4{op_r}}) + c.
  - The 4-bit sum shifts into the top of working register acc; acc shifts right by 4.
  - sa and sb shift right by 4. c takes the slice carry out.
  - On the last nibble (idx = WORDS−1), the slice MSB inputs determine overflow: overflow = (a_msb == b'_msb) AND (sum_msb != a_msb), where b' is the inverted b for subtract.
  - When idx = WORDS−1:
    - Load result from the completed acc, cout from the slice carry out and overflow as above.
    - Go to DONE.
  - Otherwise increment idx.
- **DONE:** done=1 for this single cycle, then unconditionally go to IDLE.
- start is ignored in RUN and DONE; it is not queued. A request must be re-asserted in IDLE.
- op, a and b may change freely after the start cycle. Latched copies are used.
- result, cout and overflow change only on the edge that enters DONE. They hold through IDLE and the next RUN.
- **Reset**, at any time including mid-RUN:
  - State goes to IDLE; idx, c, sa, sb and acc clear to 0.
  - busy=0, done=0, result=0, cout=0, overflow=0.
  - An aborted operation produces no done and does not update result.
- rst has priority over start in the same cycle.

## Timing

- Start is sampled high in IDLE at edge k.
- RUN occupies the cycles after edges k through k+WORDS−1 and processes nibble 0..WORDS−1.
- Edge k+WORDS enters DONE. done is high for the cycle after that edge.
- Edge k+WORDS+1 returns to IDLE.
- Latency from start edge to done edge is WORDS edges. Throughput is one operation per WORDS+2 cycles.
- The earliest next start is sampled at edge k+WORDS+2.
- busy rises after edge k and falls after edge k+WORDS+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure

- Shared package `addsub_pkg` holds:
  - the state enumeration `addsub_state_t` (IDLE, RUN, DONE);
  - the constant `NIBBLE_W = 4`;
  - the op encodings `OP_ADD = 1'b0` and `OP_SUB = 1'b1`.
- One sub-module, `addsub4_slice`:
  - combinational 4-bit adder/subtractor;
  - inputs a[3:0], b[3:0], m and cin; outputs s[3:0] and cout;
  - inverts b internally when m=1.
- The controller drives cin from register c. It is the slice's only instance.

## Test plan

All cases use WORDS=4 unless noted.

- **Add, no carry:** start, op=0, a=0x1234, b=0x0FFF → done exactly 4 edges after the start edge; result=0x2233, cout=0, overflow=0.
- **Subtract with borrow:** op=1, a=0x0005, b=0x0007 → result=0xFFFE, cout=0, overflow=0. For a=0xABCD, b=0xABCD → result=0x0000, cout=1.
- **Signed overflow:** op=0, 0x7FFF+0x0001 → result=0x8000, overflow=1, cout=0. Then op=1, 0x8000−0x0001 → result=0x7FFF, overflow=1, cout=1.
- **Start ignored while busy:** pulse start with new operands in RUN and in DONE → no effect. The first operation's result is unchanged, one done pulse, busy timing as specified.
- **Reset mid-operation:** assert rst two cycles into RUN → next cycle busy=0, done=0, result=0. No done follows. A fresh start then completes correctly.
- **WORDS=2 (8-bit):** op=0, 0xFF+0x01 → result=0x00, cout=1, overflow=0, done 2 edges after the start edge.
